load_store_unit: RTL

// Memory-side responder to the decoder's memory controls (EscMem, readMem, byteMem/halfMem/wordMem, signalMem).

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// bus geometry and the registered bus-beat payload.
package lsu_pkg;

  localparam int unsigned BUS_W     = 64;
  localparam int unsigned BUS_BYTES = BUS_W / 8;
  localparam int unsigned OFF_W     = 3;
  localparam int unsigned LINE_W    = BUS_W - OFF_W;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  typedef struct packed {
    logic                 we;
    logic [BUS_W-1:0]     addr;
    logic [BUS_BYTES-1:0] be;
    logic [BUS_W-1:0]     wdata;
  } mem_beat_t;

  function automatic logic [3:0] size_bytes(input size_t sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Narrowest flag wins when several size flags are set.
  function automatic size_t size_decode(input logic b, input logic h, input logic w);
    if (b)      return SZ_B;
    else if (h) return SZ_H;
    else if (w) return SZ_W;
    else        return SZ_D;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and write-data shifting for both beats,
// plus read-data assembly from up to two beats and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t                sz,
  input  logic [OFF_W-1:0]     off,
  input  logic                 sign_ext,
  input  logic [BUS_W-1:0]     wdata,
  input  logic [BUS_W-1:0]     rd_lo,
  input  logic [BUS_W-1:0]     rd_hi,
  output logic [BUS_BYTES-1:0] be0_c,
  output logic [BUS_BYTES-1:0] be1_c,
  output logic [BUS_W-1:0]     wd0_c,
  output logic [BUS_W-1:0]     wd1_c,
  output logic [BUS_W-1:0]     rext_c
);

  logic [BUS_BYTES-1:0]   mask;
  logic [2*BUS_BYTES-1:0] be_wide;
  logic [2*BUS_W-1:0]     wd_wide;
  logic [BUS_W-1:0]       raw;
  logic [5:0]             sh;

  // Shifting into a double-width vector gives beat0 in the low half and the
  // spill-over for beat1 in the high half.
  always_comb begin
    sh = {off, 3'b000};
    case (sz)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    be_wide = {8'h00, mask} << off;
    wd_wide = {{BUS_W{1'b0}}, wdata} << sh;
    be0_c   = be_wide[BUS_BYTES-1:0];
    be1_c   = be_wide[2*BUS_BYTES-1:BUS_BYTES];
    wd0_c   = wd_wide[BUS_W-1:0];
    wd1_c   = wd_wide[2*BUS_W-1:BUS_W];
    raw     = BUS_W'({rd_hi, rd_lo} >> sh);
    case (sz)
      SZ_B:    rext_c = {{56{sign_ext & raw[7]}},  raw[7:0]};
      SZ_H:    rext_c = {{48{sign_ext & raw[15]}}, raw[15:0]};
      SZ_W:    rext_c = {{32{sign_ext & raw[31]}}, raw[31:0]};
      default: rext_c = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one load or store per start pulse on a 64-bit aligned
// req/ready bus, splitting boundary-crossing accesses into two beats.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 EscMem,
  input  logic                 readMem,
  input  logic                 byteMem,
  input  logic                 halfMem,
  input  logic                 wordMem,
  input  logic                 signalMem,
  input  logic [BUS_W-1:0]     addr,
  input  logic [BUS_W-1:0]     wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BUS_W-1:0]     rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_W-1:0]     mem_addr,
  output logic [BUS_BYTES-1:0] mem_be,
  output logic [BUS_W-1:0]     mem_wdata,
  input  logic                 mem_ready,
  input  logic [BUS_W-1:0]     mem_rdata
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nx;
  mem_beat_t         beat, beat_nx;
  logic              req_nx, done_nx, err_nx;
  logic [BUS_W-1:0]  rdata_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;

  logic              we_q, sign_q, split_q;
  size_t             sz_q;
  logic [OFF_W-1:0]  off_q;
  logic [LINE_W-1:0] line_q;
  logic [BUS_W-1:0]  wdata_q, rbuf0;

  size_t             sz_in, a_sz;
  logic [OFF_W-1:0]  a_off;
  logic [BUS_W-1:0]  a_wdata, rd_lo, rd_hi;
  logic [BUS_BYTES-1:0] be0_c, be1_c;
  logic [BUS_W-1:0]  wd0_c, wd1_c, rext_c;
  logic              idle, start_ok, start_bad, xfer, stall, tmo, split_in;

  assign sz_in     = size_decode(byteMem, halfMem, wordMem);
  assign idle      = (state == IDLE);
  assign start_ok  = start & (EscMem ^ readMem);
  assign start_bad = start & EscMem & readMem;
  assign split_in  = (4'(addr[OFF_W-1:0]) + size_bytes(sz_in)) > 4'd8;
  assign xfer      = mem_req & mem_ready;
  assign stall     = mem_req & ~mem_ready;
  assign tmo       = stall & (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // Beat0 fields are launched on the start edge, so the aligner sees live inputs in IDLE.
  assign a_sz    = idle ? sz_in : sz_q;
  assign a_off   = idle ? addr[OFF_W-1:0] : off_q;
  assign a_wdata = idle ? wdata : wdata_q;
  assign rd_lo   = (state == BEAT1) ? rbuf0 : mem_rdata;
  assign rd_hi   = (state == BEAT1) ? mem_rdata : '0;

  lsu_align u_align (
    .sz       (a_sz),
    .off      (a_off),
    .sign_ext (sign_q),
    .wdata    (a_wdata),
    .rd_lo    (rd_lo),
    .rd_hi    (rd_hi),
    .be0_c    (be0_c),
    .be1_c    (be1_c),
    .wd0_c    (wd0_c),
    .wd1_c    (wd1_c),
    .rext_c   (rext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_ok)       state_nx = BEAT0;
        else if (start_bad) state_nx = FIN;
      end
      BEAT0: begin
        if (xfer)     state_nx = split_q ? BEAT1 : FIN;
        else if (tmo) state_nx = FIN;
      end
      BEAT1:   if (xfer || tmo) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // BEAT1 opens with one idle-bus cycle before its request is raised.
  always_comb begin
    beat_nx  = beat;
    req_nx   = mem_req;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    rdata_nx = rdata;
    tcnt_nx  = tcnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          req_nx        = 1'b1;
          beat_nx.we    = EscMem;
          beat_nx.addr  = {addr[BUS_W-1:OFF_W], 3'b000};
          beat_nx.be    = be0_c;
          beat_nx.wdata = wd0_c;
          tcnt_nx       = '0;
        end else if (start_bad) begin
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end
      end
      BEAT0, BEAT1: begin
        if (state == BEAT1 && !mem_req) begin
          req_nx        = 1'b1;
          beat_nx.addr  = {line_q + LINE_W'(1), 3'b000};
          beat_nx.be    = be1_c;
          beat_nx.wdata = wd1_c;
          tcnt_nx       = '0;
        end else if (xfer) begin
          req_nx = 1'b0;
          if (!(state == BEAT0 && split_q)) begin
            done_nx = 1'b1;
            if (!we_q) rdata_nx = rext_c;
          end
        end else if (tmo) begin
          req_nx   = 1'b0;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end else if (stall) begin
          tcnt_nx = tcnt + TCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= '0;
      mem_req <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      tcnt    <= '0;
    end else begin
      beat    <= beat_nx;
      mem_req <= req_nx;
      done    <= done_nx;
      err     <= err_nx;
      busy    <= (state_nx != IDLE);
      rdata   <= rdata_nx;
      tcnt    <= tcnt_nx;
    end
  end

  // Request capture and first-beat read buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      sz_q    <= SZ_B;
      off_q   <= '0;
      line_q  <= '0;
      wdata_q <= '0;
      rbuf0   <= '0;
    end else begin
      if (idle && start_ok) begin
        we_q    <= EscMem;
        sign_q  <= signalMem;
        split_q <= split_in;
        sz_q    <= sz_in;
        off_q   <= addr[OFF_W-1:0];
        line_q  <= addr[BUS_W-1:OFF_W];
        wdata_q <= wdata;
      end
      if (state == BEAT0 && xfer) rbuf0 <= mem_rdata;
    end
  end

  assign mem_we    = beat.we;
  assign mem_addr  = beat.addr;
  assign mem_be    = beat.be;
  assign mem_wdata = beat.wdata;

endmodule
